// File: rtl/popcount_accumulator.sv
// Streams WORD_WIDTH-bit words through one popcount datapath, sums them per
// bitmask and presents the total (plus word count) on a valid/ready port.
module popcount_word #(
    parameter int W  = 32,
    parameter int PW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_word,
    output logic [PW-1:0] o_count
);
    always_comb begin
        o_count = '0;
        for (int i = 0; i < W; i++) o_count = o_count + PW'(i_word[i]);
    end
endmodule

module popcount_accumulator #(
    parameter int WORD_WIDTH = 32,
    parameter int WORD_COUNT = 8
) (
    input  logic                                         clock,
    input  logic                                         clear,
    input  logic                                         word_in_valid,
    output logic                                         word_in_ready,
    input  logic [WORD_WIDTH-1:0]                        word_in,
    input  logic                                         word_in_last,
    output logic                                         count_out_valid,
    input  logic                                         count_out_ready,
    output logic [$clog2(WORD_WIDTH*WORD_COUNT+1)-1:0]   count_out,
    output logic [$clog2(WORD_COUNT+1)-1:0]              words_out
);
    localparam int COUNT_WIDTH = $clog2(WORD_WIDTH * WORD_COUNT + 1);
    localparam int INDEX_WIDTH = $clog2(WORD_COUNT + 1);
    localparam int POP_WIDTH   = $clog2(WORD_WIDTH + 1);
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(WORD_COUNT - 1);
    localparam logic [INDEX_WIDTH-1:0] IDX_ONE    = INDEX_WIDTH'(1);

    typedef enum logic {ACCUMULATE, OUTPUT} state_t;

    state_t                 r_state;
    logic [COUNT_WIDTH-1:0] r_acc;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [INDEX_WIDTH-1:0] r_index;
    logic [INDEX_WIDTH-1:0] r_words;
    logic                   r_valid;

    logic [POP_WIDTH-1:0]   w_pop;
    logic [COUNT_WIDTH-1:0] w_sum;
    logic                   w_accept;
    logic                   w_end;

    popcount_word #(.W(WORD_WIDTH), .PW(POP_WIDTH)) u_pop (
        .i_word  (word_in),
        .o_count (w_pop)
    );

    assign word_in_ready   = (r_state == ACCUMULATE) && !clear;
    assign w_accept        = word_in_valid && word_in_ready;
    // A full bitmask closes itself even if the producer never flags last.
    assign w_end           = word_in_last || (r_index == LAST_INDEX);
    assign w_sum           = r_acc + COUNT_WIDTH'(w_pop);
    assign count_out       = r_count;
    assign words_out       = r_words;
    assign count_out_valid = r_valid;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= ACCUMULATE;
            r_acc   <= '0;
            r_index <= '0;
            r_count <= '0;
            r_words <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ACCUMULATE: begin
                    if (w_accept) begin
                        if (w_end) begin
                            r_count <= w_sum;
                            r_words <= r_index + IDX_ONE;
                            r_acc   <= '0;
                            r_index <= '0;
                            r_valid <= 1'b1;
                            r_state <= OUTPUT;
                        end else begin
                            r_acc   <= w_sum;
                            r_index <= r_index + IDX_ONE;
                        end
                    end
                end
                OUTPUT: begin
                    if (count_out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ACCUMULATE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_popcount_accumulator.sv
// Directed checks of popcount_accumulator (8-bit x4), plus randomized bitmasks
// on that instance and on a 7-bit x1 instance against a reference sum.
module tb_popcount_accumulator;
    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    logic       a_v, a_rdy, a_last, a_ov, a_cr;
    logic [7:0] a_w;
    logic [5:0] a_cnt;
    logic [2:0] a_words;

    logic       b_v, b_rdy, b_last, b_ov, b_cr;
    logic [6:0] b_w;
    logic [2:0] b_cnt;
    logic       b_words;

    int n_cmp = 0;
    int n_err = 0;

    popcount_accumulator #(.WORD_WIDTH(8), .WORD_COUNT(4)) dut_a (
        .clock(clock), .clear(clear),
        .word_in_valid(a_v), .word_in_ready(a_rdy), .word_in(a_w), .word_in_last(a_last),
        .count_out_valid(a_ov), .count_out_ready(a_cr), .count_out(a_cnt), .words_out(a_words)
    );

    popcount_accumulator #(.WORD_WIDTH(7), .WORD_COUNT(1)) dut_b (
        .clock(clock), .clear(clear),
        .word_in_valid(b_v), .word_in_ready(b_rdy), .word_in(b_w), .word_in_last(b_last),
        .count_out_valid(b_ov), .count_out_ready(b_cr), .count_out(b_cnt), .words_out(b_words)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] w, input logic last);
        a_v = 1'b1; a_w = w; a_last = last;
        @(negedge clock);
        a_v = 1'b0;
    endtask

    task automatic chk_total(input string tag, input int cnt, input int words);
        chk({tag, "_valid"}, a_ov, 1);
        chk({tag, "_count"}, a_cnt, cnt);
        chk({tag, "_words"}, a_words, words);
        chk({tag, "_ready"}, a_rdy, 0);
    endtask

    task automatic handshake(input string tag);
        a_cr = 1'b1;
        @(negedge clock);
        a_cr = 1'b0;
        chk({tag, "_drop"}, a_ov, 0);
        chk({tag, "_rdy"}, a_rdy, 1);
    endtask

    task automatic rand_run(input bit selb);
        int nw, exp_sum, exp_n;
        logic [7:0] rw;
        logic lst;
        for (int b = 0; b < 1000; b++) begin
            nw = selb ? 1 : int'($urandom_range(1, 4));
            exp_sum = 0; exp_n = 0;
            for (int k = 0; k < nw; k++) begin
                while ($urandom_range(0, 3) == 0) @(negedge clock);
                rw  = 8'($urandom);
                lst = (k == nw - 1) && ((!selb && nw < 4) || ($urandom_range(0, 1) == 1));
                chk("rand_ready", selb ? b_rdy : a_rdy, 1);
                if (selb) begin b_v = 1'b1; b_w = rw[6:0]; b_last = lst; end
                else      begin a_v = 1'b1; a_w = rw;      a_last = lst; end
                exp_sum += selb ? $countones(rw[6:0]) : $countones(rw);
                exp_n++;
                @(negedge clock);
                a_v = 1'b0; b_v = 1'b0;
            end
            repeat ($urandom_range(0, 3)) begin
                chk("rand_hold", selb ? b_ov : a_ov, 1);
                @(negedge clock);
            end
            chk("rand_valid", selb ? b_ov : a_ov, 1);
            chk("rand_count", selb ? 32'(b_cnt) : 32'(a_cnt), exp_sum);
            chk("rand_words", selb ? 32'(b_words) : 32'(a_words), exp_n);
            if (selb) b_cr = 1'b1; else a_cr = 1'b1;
            @(negedge clock);
            a_cr = 1'b0; b_cr = 1'b0;
        end
    endtask

    initial begin
        clear = 1'b1;
        a_v = 1'b0; a_w = '0; a_last = 1'b0; a_cr = 1'b0;
        b_v = 1'b0; b_w = '0; b_last = 1'b0; b_cr = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_ready", a_rdy, 0);
        chk("rst_valid", a_ov, 0);
        chk("rst_count", a_cnt, 0);
        chk("rst_words", a_words, 0);
        clear = 1'b0;
        @(negedge clock);
        chk("idle_ready", a_rdy, 1);

        // four words, last on the fourth
        drive(8'hFF, 0); drive(8'h01, 0); drive(8'h00, 0); drive(8'h80, 1);
        chk_total("t1", 10, 4);

        // consumer back-pressure: total held, offered word not taken
        a_v = 1'b1; a_w = 8'hFF; a_last = 1'b1;
        repeat (5) begin
            @(negedge clock);
            chk_total("t4_hold", 10, 4);
        end
        a_cr = 1'b1;
        @(negedge clock);
        a_cr = 1'b0;
        chk("t4_drop", a_ov, 0);
        chk("t4_rdy", a_rdy, 1);
        @(negedge clock);
        a_v = 1'b0;
        chk_total("t4_next", 8, 1);
        handshake("t4");

        drive(8'h0F, 0); drive(8'hF0, 1);
        chk_total("t2", 8, 2);
        handshake("t2");

        // forced end without last
        repeat (4) drive(8'hFF, 0);
        chk_total("t3", 32, 4);
        handshake("t3");

        drive(8'h00, 1);
        chk_total("zero", 0, 1);
        handshake("zero");

        // input gaps leave the partial sum intact
        drive(8'hFF, 0);
        repeat (3) @(negedge clock);
        chk("stall_valid", a_ov, 0);
        drive(8'h01, 1);
        chk_total("stall", 9, 2);
        handshake("stall");

        // clear mid-bitmask discards the partial 16
        drive(8'hFF, 0); drive(8'hFF, 0);
        clear = 1'b1;
        @(negedge clock);
        chk("t5_clr_ready", a_rdy, 0);
        chk("t5_clr_valid", a_ov, 0);
        clear = 1'b0;
        drive(8'h03, 1);
        chk_total("t5", 2, 1);
        handshake("t5");

        rand_run(1'b0);
        rand_run(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
